// File: rtl/bus_slave_regs.sv
// Bus slave register block: six R/W registers, a transaction counter and a cycle
// counter, answering to one slave index with a fixed number of wait states.
module bus_slave_regs #(
  parameter logic [2:0]  SLAVE_INDEX = 3'd2,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] sAddr,
  input  logic        sAs_,
  input  logic        sRW,
  input  logic [31:0] sWrData,
  output logic [31:0] sRdData,
  output logic        sRdy_,
  output logic [31:0] CtrlOut
);

  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [2:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] regs_q [6];
  logic [31:0] regs_d [6];
  logic [31:0] txn_q, txn_d;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] rd_q, rd_d;
  logic        rdy_n_q, rdy_n_d;

  logic        accept;
  logic        enter_ready;
  logic [2:0]  ent_addr;
  logic        ent_rw;
  logic [31:0] ent_wdata;
  logic [31:0] rd_mux;

  // Only the slave-index and register-select bits of the address are decoded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^sAddr[26:3];

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    regs_d      = regs_q;
    txn_d       = txn_q;
    cyc_d       = cyc_q + 32'd1;
    rd_d        = rd_q;
    rdy_n_d     = rdy_n_q;
    enter_ready = 1'b0;

    accept = (state_q == IDLE) && !sAs_ && (sAddr[29:27] == SLAVE_INDEX);

    // With zero wait states READY is entered straight from IDLE, before the
    // latched copies exist, so the live bus values are used on that path.
    ent_addr  = (state_q == IDLE) ? sAddr[2:0] : addr_q;
    ent_rw    = (state_q == IDLE) ? sRW        : rw_q;
    ent_wdata = (state_q == IDLE) ? sWrData    : wdata_q;

    case (ent_addr)
      3'd0:    rd_mux = regs_q[0];
      3'd1:    rd_mux = regs_q[1];
      3'd2:    rd_mux = regs_q[2];
      3'd3:    rd_mux = regs_q[3];
      3'd4:    rd_mux = regs_q[4];
      3'd5:    rd_mux = regs_q[5];
      3'd6:    rd_mux = txn_q;
      default: rd_mux = cyc_q;
    endcase

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = sAddr[2:0];
          rw_d    = sRW;
          wdata_d = sWrData;
          if (WAIT_CYCLES == 0) begin
            state_d     = READY;
            enter_ready = 1'b1;
          end else begin
            state_d = WAIT;
            wcnt_d  = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d     = READY;
          enter_ready = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      READY: begin
        state_d = IDLE;
        rdy_n_d = 1'b1;
        rd_d    = '0;
        txn_d   = txn_q + 32'd1;
      end
      default: state_d = IDLE;
    endcase

    if (enter_ready) begin
      rdy_n_d = 1'b0;
      rd_d    = ent_rw ? rd_mux : 32'd0;
      for (int i = 0; i < 6; i++) begin
        if (!ent_rw && ent_addr == 3'(i)) regs_d[i] = ent_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      for (int i = 0; i < 6; i++) regs_q[i] <= '0;
      txn_q   <= '0;
      cyc_q   <= '0;
      rd_q    <= '0;
      rdy_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      regs_q  <= regs_d;
      txn_q   <= txn_d;
      cyc_q   <= cyc_d;
      rd_q    <= rd_d;
      rdy_n_q <= rdy_n_d;
    end
  end

  assign sRdData = rd_q;
  assign sRdy_   = rdy_n_q;
  assign CtrlOut = regs_q[0];

endmodule

// File: tb/tb_bus_slave_regs.sv
// Directed bench for bus_slave_regs: one instance with default parameters
// (index 2, two wait states) and one at index 3 with zero wait states.
module tb_bus_slave_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] sAddr;
  logic        sAs_;
  logic        sRW;
  logic [31:0] sWrData;
  logic [31:0] rd_a, rd_b, ctrl_a, ctrl_b;
  logic        rdy_a, rdy_b;

  always #5 clk = ~clk;

  bus_slave_regs u_a (
    .clk(clk), .reset(reset), .sAddr(sAddr), .sAs_(sAs_), .sRW(sRW),
    .sWrData(sWrData), .sRdData(rd_a), .sRdy_(rdy_a), .CtrlOut(ctrl_a)
  );

  bus_slave_regs #(.SLAVE_INDEX(3'd3), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .reset(reset), .sAddr(sAddr), .sAs_(sAs_), .sRW(sRW),
    .sWrData(sWrData), .sRdData(rd_b), .sRdy_(rdy_b), .CtrlOut(ctrl_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int          r_cyc, r_pulses;
  logic [31:0] r_dat, r_out, r_ctrl, r_ctrl_prev;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic rdy_of(input logic sel);
    return sel ? rdy_b : rdy_a;
  endfunction

  function automatic logic [31:0] rd_of(input logic sel);
    return sel ? rd_b : rd_a;
  endfunction

  function automatic logic [31:0] ctrl_of(input logic sel);
    return sel ? ctrl_b : ctrl_a;
  endfunction

  task automatic bus_idle();
    sAs_    = 1'b1;
    sAddr   = 30'h0;
    sWrData = 32'hFFFF_FFFF;
    sRW     = 1'b1;
  endtask

  // Strobe for one cycle (edge T), scramble the bus afterwards, then watch
  // cycles T+1..T+6 of the selected instance. dbl re-strobes during T+1.
  task automatic xact(input logic sel, input logic [2:0] idx, input logic [2:0] r,
                      input logic rw, input logic [31:0] wd, input logic dbl);
    logic [31:0] last_ctrl;
    sAddr   = {idx, 24'h0, r};
    sAs_    = 1'b0;
    sRW     = rw;
    sWrData = wd;
    @(posedge clk);
    #1;
    if (dbl) begin
      sAs_    = 1'b0;
      sAddr   = {idx, 24'h0, r};
      sWrData = 32'h99;
      sRW     = 1'b0;
    end else begin
      bus_idle();
    end
    r_cyc = -1; r_pulses = 0; r_dat = '0; r_out = '0; r_ctrl = '0; r_ctrl_prev = '0;
    last_ctrl = ctrl_of(sel);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (rdy_of(sel) == 1'b0) begin
        r_pulses++;
        if (r_cyc < 0) begin
          r_cyc       = c;
          r_dat       = rd_of(sel);
          r_ctrl      = ctrl_of(sel);
          r_ctrl_prev = last_ctrl;
        end
      end else begin
        r_out |= rd_of(sel);
      end
      last_ctrl = ctrl_of(sel);
      @(posedge clk);
      #1;
      bus_idle();
    end
  endtask

  initial begin
    int pulses;
    reset = 1'b1;
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy_a", 32'(rdy_a), 32'd1);
    check("rst_rd_a", rd_a, 32'd0);
    check("rst_ctrl_a", ctrl_a, 32'd0);
    check("rst_rdy_b", 32'(rdy_b), 32'd1);
    reset = 1'b0;

    // Strobe in the first cycle after release, two wait states
    xact(1'b0, 3'd2, 3'd0, 1'b0, 32'hDEADBEEF, 1'b0);
    check("w0_rdy_cycle", 32'(r_cyc), 32'd3);
    check("w0_pulses", 32'(r_pulses), 32'd1);
    check("w0_rd_in_rdy", r_dat, 32'd0);
    check("w0_rd_outside", r_out, 32'd0);
    check("w0_ctrl_in_rdy", r_ctrl, 32'hDEADBEEF);
    check("w0_ctrl_before", r_ctrl_prev, 32'd0);

    // Zero wait states on instance b
    xact(1'b1, 3'd3, 3'd0, 1'b0, 32'hDEADBEEF, 1'b0);
    check("b_w0_rdy_cycle", 32'(r_cyc), 32'd1);
    check("b_ctrl", ctrl_b, 32'hDEADBEEF);
    xact(1'b1, 3'd3, 3'd0, 1'b1, 32'h0, 1'b0);
    check("b_r0_rdy_cycle", 32'(r_cyc), 32'd1);
    check("b_r0_data", r_dat, 32'hDEADBEEF);
    check("b_r0_rd_outside", r_out, 32'd0);

    // Foreign slave index is ignored
    xact(1'b0, 3'd1, 3'd0, 1'b0, 32'h1111, 1'b0);
    check("foreign_pulses", 32'(r_pulses), 32'd0);
    check("foreign_ctrl", ctrl_a, 32'hDEADBEEF);
    xact(1'b0, 3'd2, 3'd0, 1'b1, 32'h0, 1'b0);
    check("r0_after_foreign", r_dat, 32'hDEADBEEF);

    // Transaction counter: two done so far, two more, then read reg 6
    xact(1'b0, 3'd2, 3'd1, 1'b0, 32'hA5A5, 1'b0);
    xact(1'b0, 3'd2, 3'd6, 1'b0, 32'h1234, 1'b0);
    check("w6_acked", 32'(r_pulses), 32'd1);
    xact(1'b0, 3'd2, 3'd6, 1'b1, 32'h0, 1'b0);
    check("r6_count", r_dat, 32'd4);
    xact(1'b0, 3'd2, 3'd1, 1'b1, 32'h0, 1'b0);
    check("r1_data", r_dat, 32'hA5A5);

    // Second strobe during WAIT has no effect
    xact(1'b0, 3'd2, 3'd2, 1'b0, 32'h77, 1'b1);
    check("dbl_pulses", 32'(r_pulses), 32'd1);
    check("dbl_rdy_cycle", 32'(r_cyc), 32'd3);
    xact(1'b0, 3'd2, 3'd2, 1'b1, 32'h0, 1'b0);
    check("dbl_r2_data", r_dat, 32'h77);

    // Reset mid-WAIT of a write of 0x55 to reg 1
    sAddr = {3'd2, 24'h0, 3'd1}; sAs_ = 1'b0; sRW = 1'b0; sWrData = 32'h55;
    @(posedge clk);
    #1;
    bus_idle();
    #2 reset = 1'b1;
    #1;
    check("rst_mid_rdy", 32'(rdy_a), 32'd1);
    check("rst_mid_ctrl", ctrl_a, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rdy_a == 1'b0) pulses++;
      @(posedge clk);
      #1;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);
    xact(1'b0, 3'd2, 3'd6, 1'b1, 32'h0, 1'b0);
    check("abort_r6", r_dat, 32'd0);
    xact(1'b0, 3'd2, 3'd1, 1'b1, 32'h0, 1'b0);
    check("abort_r1", r_dat, 32'd0);
    xact(1'b0, 3'd2, 3'd7, 1'b1, 32'h0, 1'b0);
    check("abort_r7", r_dat, 32'd21);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_slave_regs.md
BUS_SLAVE_REGS -- requirements
Module: bus_slave_regs

Interface
REQ-001 Parameter SLAVE_INDEX, default 3'd2: bus slave index this block answers to; compared against sAddr[29:27].
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before ready; legal range 0..15.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port clk, input, 1: clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port sAddr, input, 30: word address from the bus; bits [2:0] select a register.
REQ-007 Port sAs_, input, 1: address strobe, active low, one cycle per transaction.
REQ-008 Port sRW, input, 1: 1 = read, 0 = write; sampled with sAs_.
REQ-009 Port sWrData, input, 32: write data; sampled with sAs_.
REQ-010 Port sRdData, output, 32: read data; valid only while sRdy_ is low, 0 otherwise.
REQ-011 Port sRdy_, output, 1: ready, active low, one cycle per accepted transaction.
REQ-012 Port CtrlOut, output, 32: current contents of register 0.

Function
REQ-013 Register map:
- regs 0..5: 32-bit read/write.
- reg 6: read-only transaction counter.
- reg 7: read-only free-running cycle counter.
REQ-014 A transaction is accepted in IDLE only, when sAs_ = 0 and sAddr[29:27] = SLAVE_INDEX.
REQ-015 On acceptance the block SHALL latch sAddr[2:0], sRW and sWrData; later bus input changes have no effect.
REQ-016 FSM states are IDLE, WAIT and READY.
REQ-017 IDLE transitions on acceptance:
- to READY when WAIT_CYCLES = 0;
- otherwise to WAIT, loading a 4-bit counter with WAIT_CYCLES-1.
REQ-018 WAIT decrements the counter each cycle and moves to READY in the cycle after the counter reads 0.
REQ-019 READY lasts exactly one cycle, then returns unconditionally to IDLE.
REQ-020 sAs_ sampled in any non-IDLE state SHALL be ignored; no queuing.
REQ-021 sRdy_ and sRdData SHALL be registered, driven by the READY state.
REQ-022 Timing: strobe sampled at edge T; sRdy_ = 0 during cycle T+1+WAIT_CYCLES; sRdy_ = 1 in all other cycles.
REQ-023 A write to regs 0..5 SHALL commit at the edge entering READY, so CtrlOut updates in the READY cycle.
REQ-024 Writes to regs 6 and 7 complete with sRdy_ but change nothing.
REQ-025 A read SHALL load sRdData at the edge entering READY with the register value at that edge.
REQ-026 sRdData SHALL return to 0 at the edge leaving READY.
REQ-027 During a write's READY cycle, sRdData SHALL be 0.
REQ-028 Reg 6 SHALL increment by 1 at each edge leaving READY, reads and writes alike, wrapping 0xFFFFFFFF -> 0.
REQ-029 Reg 7 SHALL increment every cycle out of reset, wrapping 0xFFFFFFFF -> 0.
REQ-030 A read of reg 7 returns its value at the sampling edge of REQ-025.
REQ-031 Strobes whose index differs from SLAVE_INDEX SHALL be ignored entirely; no state change.

Reset
REQ-032 Reset SHALL act asynchronously and force:
- FSM to IDLE, wait counter to 0;
- regs 0..7 to 0, so CtrlOut = 0;
- sRdData to 0, sRdy_ to 1.
REQ-033 Reset during WAIT or READY SHALL abort the transaction: no write commit, no reg 6 increment, no sRdy_ pulse after release.
REQ-034 In the first cycle after reset release the block SHALL accept a strobe normally.

Verification
REQ-035 WAIT_CYCLES=2: write reg 0 = 0xDEADBEEF, strobe at edge T -> sRdy_ = 0 only in cycle T+3, CtrlOut = 0xDEADBEEF from T+3, sRdData = 0 throughout.
REQ-036 WAIT_CYCLES=0: read reg 0 after REQ-035 -> sRdy_ = 0 in cycle T+1 with sRdData = 0xDEADBEEF; sRdData = 0 in cycle T+2.
REQ-037 Address with sAddr[29:27] = 3'd1, sAs_ = 0 -> no sRdy_ pulse, regs unchanged, reg 6 unchanged.
REQ-038 Three transactions, then write 0x1234 to reg 6, then read reg 6 -> read returns 4; the write is acknowledged but ignored.
REQ-039 Second sAs_ strobe during WAIT -> exactly one sRdy_ pulse; second strobe has no effect.
REQ-040 Reset asserted mid-WAIT of a write of 0x55 to reg 1 -> after release reg 1 = 0, reg 6 = 0, no sRdy_ pulse, and a read of reg 7 shows the count restarted from 0.
